controle_horner_param: RTL and testbench

- Parametrised successor of the fixed 9-state polynomial controller.
- Sequences a shared datapath (X, H, S registers; multiplier; adder; coefficient memory) to evaluate S = a_GRAU*x^GRAU + … + a_0 by Horner's rule, for any compile-time degree GRAU.
- Adds a coefficient-index output, a done/acknowledge handshake, a synchronous abort, and a busy flag.

---
 rtl/controle_horner_param.sv | 126 ++++++++++++
 tb/tb_controle_horner_param.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/controle_horner_param.sv
// Horner-rule sequencer for a shared X/H/S datapath, degree GRAU.
// Moore strobes from state; coef_idx is a registered memory address.
module controle_horner_param #(
   parameter int GRAU  = 3,
   parameter int IDX_W = (GRAU < 1) ? 1 : $clog2(GRAU + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inicio,
   input  logic             ack,
   input  logic             abort,
   output logic             LX,
   output logic             LH,
   output logic             LS,
   output logic [1:0]       M0,
   output logic [IDX_W-1:0] coef_idx,
   output logic             ocupado,
   output logic             pronto
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD_X  = 3'd1,
      LOAD_AN = 3'd2,
      MUL     = 3'd3,
      ADD     = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(GRAU);
   localparam logic [IDX_W-1:0] IDX_NXT =
      IDX_W'((GRAU > 0) ? GRAU - 1 : 0);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [IDX_W-1:0] idx_q;
   logic [IDX_W-1:0] idx_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         idx_q <= '0;
      end else begin
         state <= state_nxt;
         idx_q <= idx_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx_q;
      LX        = 1'b0;
      LH        = 1'b0;
      LS        = 1'b0;
      M0        = 2'd0;
      ocupado   = 1'b0;
      pronto    = 1'b0;
      case (state)
         IDLE: begin
            if (inicio) state_nxt = LOAD_X;
         end
         LOAD_X: begin
            LX      = 1'b1;
            ocupado = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               state_nxt = LOAD_AN;
               idx_nxt   = IDX_TOP;
            end
         end
         LOAD_AN: begin
            LS      = 1'b1;
            M0      = 2'd1;
            ocupado = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else if (GRAU == 0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = MUL;
               idx_nxt   = IDX_NXT;
            end
         end
         MUL: begin
            LH      = 1'b1;
            ocupado = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               state_nxt = ADD;
            end
         end
         ADD: begin
            LS      = 1'b1;
            M0      = 2'd2;
            ocupado = 1'b1;
            if (abort) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else if (idx_q == '0) begin
               state_nxt = DONE;
            end else begin
               state_nxt = MUL;
               idx_nxt   = idx_q - IDX_ONE;
            end
         end
         DONE: begin
            pronto = 1'b1;
            if (ack || abort) state_nxt = IDLE;
         end
         // stray encodings fall back to a clean idle
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase
   end

   assign coef_idx = idx_q;

endmodule

// File: tb/tb_controle_horner_param.sv
// Randomised bench for controle_horner_param at degrees 0, 3 and 255.
// Expected strobe traces and S values come from a polynomial-level model.
module tb_controle_horner_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] inicio;
   logic [2:0] ack;
   logic [2:0] abort;

   logic       lx0, lh0, ls0, oc0, pr0;
   logic [1:0] m00;
   logic [0:0] ix0;
   logic       lx3, lh3, ls3, oc3, pr3;
   logic [1:0] m03;
   logic [1:0] ix3;
   logic       lxb, lhb, lsb, ocb, prb;
   logic [1:0] m0b;
   logic [7:0] ixb;

   controle_horner_param #(.GRAU(0)) u_g0 (
      .clk(clk), .rst(rst), .inicio(inicio[0]), .ack(ack[0]),
      .abort(abort[0]), .LX(lx0), .LH(lh0), .LS(ls0), .M0(m00),
      .coef_idx(ix0), .ocupado(oc0), .pronto(pr0)
   );
   controle_horner_param #(.GRAU(3)) u_g3 (
      .clk(clk), .rst(rst), .inicio(inicio[1]), .ack(ack[1]),
      .abort(abort[1]), .LX(lx3), .LH(lh3), .LS(ls3), .M0(m03),
      .coef_idx(ix3), .ocupado(oc3), .pronto(pr3)
   );
   controle_horner_param #(.GRAU(255)) u_g255 (
      .clk(clk), .rst(rst), .inicio(inicio[2]), .ack(ack[2]),
      .abort(abort[2]), .LX(lxb), .LH(lhb), .LS(lsb), .M0(m0b),
      .coef_idx(ixb), .ocupado(ocb), .pronto(prb)
   );

   int gr[3] = '{0, 3, 255};
   int sel;

   // {ocupado, pronto, LX, LH, LS, M0, idx}
   logic [14:0] v0, v3, vb, cur;
   assign v0 = {oc0, pr0, lx0, lh0, ls0, m00, 7'd0, ix0};
   assign v3 = {oc3, pr3, lx3, lh3, ls3, m03, 6'd0, ix3};
   assign vb = {ocb, prb, lxb, lhb, lsb, m0b, ixb};
   assign cur = (sel == 0) ? v0 : (sel == 1) ? v3 : vb;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [14:0] pk(input bit oc, input bit pr,
      input bit x, input bit h, input bit s, input int m, input int i);
      return {oc, pr, x, h, s, 2'(m), 8'(i)};
   endfunction

   // behavioural datapath driven by the selected controller
   logic [31:0] coef [256];
   logic [31:0] xin, xr, hr, sr;
   always @(posedge clk) begin
      if (cur[12]) xr <= xin;
      if (cur[11]) hr <= sr * xr;
      if (cur[10])
         sr <= (cur[9:8] == 2'd1) ? coef[cur[7:0]]
                                   : hr + coef[cur[7:0]];
   end

   function automatic logic [31:0] poly(input int g, input logic [31:0] x);
      logic [31:0] acc = 0;
      logic [31:0] p = 1;
      for (int i = 0; i <= g; i++) begin
         acc += coef[i] * p;
         p   *= x;
      end
      return acc;
   endfunction

   logic [14:0] exp_q[$];

   task automatic build(input int g);
      exp_q = {};
      exp_q.push_back(pk(1, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(pk(1, 0, 0, 0, 1, 1, g));
      for (int k = g - 1; k >= 0; k--) begin
         exp_q.push_back(pk(1, 0, 0, 1, 0, 0, k));
         exp_q.push_back(pk(1, 0, 0, 0, 1, 2, k));
      end
      exp_q.push_back(pk(0, 1, 0, 0, 0, 0, 0));
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic run(input int s, input logic [31:0] xv,
                      input bit rnd_coef, input int abort_at,
                      input bit end_abort, input bit start_abort);
      int g;
      int n;
      g = gr[s];
      sel = s;
      if (rnd_coef)
         for (int i = 0; i <= g; i++) coef[i] = $urandom;
      xin = xv;
      build(g);
      n = exp_q.size();
      @(negedge clk);
      inicio[s] = 1'b1;
      abort[s]  = start_abort;
      for (int k = 0; k < n; k++) begin
         step();
         abort[s] = 1'b0;
         if (k < n - 1) begin
            inicio[s] = 1'($urandom_range(0, 1));
            ack[s]    = 1'($urandom_range(0, 1));
         end else begin
            inicio[s] = 1'b0;
            ack[s]    = 1'b0;
         end
         chk($sformatf("seq g%0d k%0d", g, k), cur, exp_q[k]);
         if (k == abort_at) begin
            abort[s] = 1'b1;
            step();
            abort[s]  = 1'b0;
            inicio[s] = 1'b0;
            ack[s]    = 1'b0;
            chk("abort idle", cur, 15'd0);
            repeat (3) begin
               step();
               chk("abort no pronto", cur, 15'd0);
            end
            return;
         end
      end
      chk($sformatf("S g%0d", g), sr, poly(g, xv));
      repeat (5) begin
         step();
         chk("done hold", cur, pk(0, 1, 0, 0, 0, 0, 0));
      end
      if (end_abort) abort[s] = 1'b1;
      else ack[s] = 1'b1;
      inicio[s] = 1'($urandom_range(0, 1));
      step();
      ack[s]    = 1'b0;
      abort[s]  = 1'b0;
      inicio[s] = 1'b0;
      chk("leave done", cur, 15'd0);
      step();
      chk("idle hold", cur, 15'd0);
   endtask

   task automatic reset_mid();
      sel = 1;
      @(negedge clk);
      inicio[1] = 1'b1;
      step();
      inicio[1] = 1'b0;
      chk("rst pre LX", cur, pk(1, 0, 1, 0, 0, 0, 0));
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst g3 mid add", v3, 15'd0);
      chk("rst g0", v0, 15'd0);
      chk("rst g255", vb, 15'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("rst release idle", cur, 15'd0);
   endtask

   initial begin
      int ab;
      rst    = 1'b0;
      inicio = '0;
      ack    = '0;
      abort  = '0;
      sel    = 1;
      xin    = '0;
      #12;
      chk("reset g0", v0, 15'd0);
      chk("reset g3", v3, 15'd0);
      chk("reset g255", vb, 15'd0);
      @(negedge clk);
      rst = 1'b1;
      step();
      chk("idle after reset", v3, 15'd0);

      coef[3] = 32'd1;
      coef[2] = 32'd0;
      coef[1] = 32'd3;
      coef[0] = 32'd5;
      run(1, 32'd2, 1'b0, -1, 1'b0, 1'b0);
      chk("S known 19", sr, 32'd19);

      coef[0] = 32'd7;
      run(0, 32'd9, 1'b0, -1, 1'b0, 1'b0);
      chk("S known 7", sr, 32'd7);

      run(1, $urandom, 1'b1, 4, 1'b0, 1'b0);
      run(1, $urandom, 1'b1, -1, 1'b0, 1'b0);

      reset_mid();
      run(1, $urandom, 1'b1, -1, 1'b0, 1'b0);

      run(1, $urandom, 1'b1, -1, 1'b0, 1'b1);
      run(1, $urandom, 1'b1, -1, 1'b1, 1'b0);

      for (int t = 0; t < 24; t++) begin
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         run(1, $urandom, 1'b1, ab, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      end
      for (int t = 0; t < 6; t++) begin
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1)) : -1;
         run(0, $urandom, 1'b1, ab, 1'($urandom_range(0, 1)), 1'b0);
      end

      run(2, $urandom, 1'b1, -1, 1'b0, 1'b0);
      run(2, $urandom, 1'b1, 300, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
